// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a wide add/sub requester and the serial adder sequencer.
interface serial_adder_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  modport master (
    output start, sub, op_a, op_b,
    input  busy, done, sum, carry_out, overflow
  );

  modport slave (
    input  start, sub, op_a, op_b,
    output busy, done, sum, carry_out, overflow
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Sequences a W-bit add/subtract through one 4-bit adder slice, LS nibble first,
// with registered results that only change when done pulses.
module serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input logic               clk,
  input logic               rst,
  serial_adder_ctrl_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_s;
  logic          r_carry;
  logic          r_msbA;
  logic          r_msbB;
  logic          r_busy;
  logic          r_done;
  logic [W-1:0]  r_sum;
  logic          r_carryOut;
  logic          r_overflow;

  logic [4:0]    w_slice;
  logic [W-1:0]  w_sNext;
  logic [W-1:0]  w_bEff;
  logic          w_last;

  assign w_slice = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'b0, r_carry};
  assign w_sNext = (r_s >> 4) | (W'(w_slice[3:0]) << (W - 4));
  assign w_bEff  = bus.sub ? ~bus.op_b : bus.op_b;
  assign w_last  = (r_cnt == CW'(NIBBLES - 1));

  // Results are captured on the final RUN edge so they are valid in the done cycle;
  // a new request is accepted from IDLE or DONE, never while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_s        <= '0;
      r_carry    <= 1'b0;
      r_msbA     <= 1'b0;
      r_msbB     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sum      <= '0;
      r_carryOut <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.op_a;
            r_b     <= w_bEff;
            r_carry <= bus.sub;
            r_msbA  <= bus.op_a[W-1];
            r_msbB  <= w_bEff[W-1];
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_s     <= w_sNext;
          r_a     <= r_a >> 4;
          r_b     <= r_b >> 4;
          r_carry <= w_slice[4];
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_sum      <= w_sNext;
            r_carryOut <= w_slice[4];
            r_overflow <= (r_msbA == r_msbB) && (w_sNext[W-1] != r_msbA);
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.sum       = r_sum;
  assign bus.carry_out = r_carryOut;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: a 4-nibble instance for the main sequence
// and a 1-nibble instance for the single-slice corner.
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.NIBBLES(4)) bus4 ();
  serial_adder_ctrl_if #(.NIBBLES(1)) bus1 ();

  serial_adder_ctrl #(.NIBBLES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  serial_adder_ctrl #(.NIBBLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  // Drives a request at a falling edge and releases start one cycle later.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic s);
    bus4.start = 1'b1;
    bus4.op_a  = a;
    bus4.op_b  = b;
    bus4.sub   = s;
    @(negedge clk);
    bus4.start = 1'b0;
  endtask

  // Called in the first RUN cycle; expects done exactly five cycles after acceptance.
  task automatic waitDone(input string tag, input logic [15:0] expSum,
                          input logic expCo, input logic expOv);
    int cycles = 1;
    int busyCycles = 0;
    int overlap = 0;
    while (!bus4.done && cycles < 20) begin
      if (bus4.busy) busyCycles++;
      @(negedge clk);
      cycles++;
    end
    if (bus4.busy && bus4.done) overlap++;
    checkOutput({tag, "_latency"}, 16'(cycles), 16'd5);
    checkOutput({tag, "_busyCycles"}, 16'(busyCycles), 16'd4);
    checkOutput({tag, "_overlap"}, 16'(overlap), 16'd0);
    checkOutput({tag, "_sum"}, bus4.sum, expSum);
    checkOutput({tag, "_carry"}, 16'(bus4.carry_out), 16'(expCo));
    checkOutput({tag, "_ovf"}, 16'(bus4.overflow), 16'(expOv));
  endtask

  initial begin
    int doneSeen;
    rst = 1'b1;
    bus4.start = 1'b1; bus4.sub = 1'b0; bus4.op_a = 16'h1111; bus4.op_b = 16'h1111;
    bus1.start = 1'b0; bus1.sub = 1'b0; bus1.op_a = 4'h0; bus1.op_b = 4'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 16'(bus4.busy), 16'd0);
    checkOutput("reset_done", 16'(bus4.done), 16'd0);
    checkOutput("reset_sum", bus4.sum, 16'h0000);
    checkOutput("reset_carry", 16'(bus4.carry_out), 16'd0);
    checkOutput("reset_ovf", 16'(bus4.overflow), 16'd0);
    bus4.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(16'h1234, 16'h0FFF, 1'b0);
    waitDone("add_basic", 16'h2233, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("done_pulse_width", 16'(bus4.done), 16'd0);
    checkOutput("hold_sum_idle", bus4.sum, 16'h2233);

    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    waitDone("add_wrap", 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0);
    waitDone("add_ovf", 16'h8000, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(16'h0005, 16'h0007, 1'b1);
    waitDone("sub_neg", 16'hFFFE, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(16'h8000, 16'h0001, 1'b1);
    waitDone("sub_ovf", 16'h7FFF, 1'b1, 1'b1);
    @(negedge clk);

    // Start pulsed mid-run with new operands must be ignored.
    applyStimulus(16'h1111, 16'h2222, 1'b0);
    bus4.start = 1'b1; bus4.op_a = 16'hAAAA; bus4.op_b = 16'h5555; bus4.sub = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    begin
      int c = 2;
      while (!bus4.done && c < 20) begin
        @(negedge clk);
        c++;
      end
      checkOutput("ignore_latency", 16'(c), 16'd5);
      checkOutput("ignore_sum", bus4.sum, 16'h3333);
    end

    // Back-to-back: start held in the done cycle.
    applyStimulus(16'h0001, 16'h0001, 1'b0);
    checkOutput("b2b_busy_restart", 16'(bus4.busy), 16'd1);
    checkOutput("b2b_hold_prev", bus4.sum, 16'h3333);
    waitDone("b2b", 16'h0002, 1'b0, 1'b0);
    @(negedge clk);

    // Reset in the second RUN cycle aborts the operation.
    applyStimulus(16'h0F0F, 16'h0101, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", 16'(bus4.busy), 16'd0);
    checkOutput("abort_done", 16'(bus4.done), 16'd0);
    checkOutput("abort_sum", bus4.sum, 16'h0000);
    checkOutput("abort_carry", 16'(bus4.carry_out), 16'd0);
    checkOutput("abort_ovf", 16'(bus4.overflow), 16'd0);
    doneSeen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus4.done || bus4.busy) doneSeen++;
    end
    checkOutput("abort_no_done", 16'(doneSeen), 16'd0);
    applyStimulus(16'h00FF, 16'h0001, 1'b0);
    waitDone("post_abort", 16'h0100, 1'b0, 1'b0);
    @(negedge clk);

    // Single-nibble instance: one RUN cycle, then DONE.
    bus1.start = 1'b1; bus1.op_a = 4'h9; bus1.op_b = 4'h8; bus1.sub = 1'b0;
    @(negedge clk);
    bus1.start = 1'b0;
    checkOutput("n1_busy", 16'(bus1.busy), 16'd1);
    checkOutput("n1_done_early", 16'(bus1.done), 16'd0);
    @(negedge clk);
    checkOutput("n1_done", 16'(bus1.done), 16'd1);
    checkOutput("n1_busy_off", 16'(bus1.busy), 16'd0);
    checkOutput("n1_sum", 16'(bus1.sum), 16'h0001);
    checkOutput("n1_carry", 16'(bus1.carry_out), 16'd1);
    checkOutput("n1_ovf", 16'(bus1.overflow), 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
